uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmit frame engine, successor to the fixed 5-way output select stage. Owns the whole TX frame: handshake data acceptance, start/data/parity/stop sequencing, and per-bit timing. It drives a registered serial line.
- Generalised in data width, bit period, parity mode and stop-bit count.
- Sits between the TX data source (FIFO or register interface) and the pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
CLKS_PER_BIT, 1, clock cycles per serial bit; legal >=1. Value 1 gives one bit per clock.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
data_in  in  DATA_WIDTH  frame payload, sent LSB first
data_valid  in  1  source has a word on data_in
data_ready  out  1  engine accepts data_in this cycle
par_en  in  1  1 = insert parity bit after data
par_type  in  1  0 = even parity, 1 = odd parity
stop2  in  1  0 = one stop bit, 1 = two stop bits
busy  out  1  frame in progress
tx_out  out  1  serial line, registered, idle high

Behaviour:
- Reset: synchronous, active-high, checked on the rising clk edge. Next edge: state=IDLE, counters=0, tx_out=1, busy=0. data_ready=0 while rst=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: accept = data_valid && data_ready at a clk edge.
  - At accept, latch data_in, par_en, par_type, stop2 and the parity bit. Even parity = XOR of data bits; odd parity = its inverse.
  - Config inputs are don't-care outside the accept edge.
- data_ready is combinational. It is 1 in IDLE, and 1 in the last clock of the last stop bit. Otherwise 0.
- Timing after accept:
  - Next cycle: START, tx_out=0, busy=1.
  - Each bit lasts exactly CLKS_PER_BIT clocks, timed by an internal baud counter that runs 0..CLKS_PER_BIT-1.
- Bit order and transitions:
  - START goes to DATA bits 0..DATA_WIDTH-1, using a bit index counter.
  - DATA goes to PARITY if latched par_en=1, else to STOP.
  - PARITY (one bit) goes to STOP.
  - STOP lasts 1 bit, or 2 bits if latched stop2=1.
- tx_out per state: START=0, DATA=latched data[idx], PARITY=latched parity, STOP=1, IDLE=1. It is registered, so it changes only on clk edges at bit boundaries.
- Frame length in clocks: CLKS_PER_BIT*(1+DATA_WIDTH+par_en+1+stop2).
- Back-to-back: accept in the last stop clock goes directly to START on the next edge. No idle gap; busy stays 1.
- End of stop with no accept: go to IDLE, busy=0, tx_out=1.
- rst mid-frame: the frame is aborted and the latched word is discarded. tx_out=1 on the next edge; no partial-frame completion.
- data_valid held high in IDLE: exactly one word is accepted per frame.
- Counter widths: clog2(DATA_WIDTH) and clog2(CLKS_PER_BIT), each with a minimum of 1. Counter wrap is at the terminal count; no overflow is possible.

Optional Feature:
Macro: UART_TX_BREAK_EN
- Defined:
  - Adds input port send_break (1 bit).
  - send_break=1 sampled in IDLE enters state BREAK: tx_out=0, busy=1, data_ready=0, held while send_break=1.
  - On deassertion, return to IDLE with tx_out=1 on the next edge.
  - send_break during a frame is ignored until the frame ends. Break then takes priority over data_valid in IDLE.
- Not defined: no send_break port, no BREAK state. Behaviour is exactly as above.

Test Plan:
- Basic frame, no parity. Setup: DATA_WIDTH=8, CLKS_PER_BIT=4, par_en=0, stop2=0; send 0xA5. Required: tx_out holds 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; busy=1 for exactly 40 clocks; data_ready=0 throughout except the last stop clock.
- Parity: 0xA5 with par_en=1. par_type=0 gives parity bit 0; par_type=1 gives parity bit 1. Frame is 44 clocks. Send 0x01 with even parity: parity bit 1.
- Two stop bits and back-to-back: stop2=1, send 0x00 then 0xFF with data_valid held high. Required: two stop bits of 1 (8 clocks), then START of 0xFF immediately with no idle clock; busy never drops between frames.
- Reset mid-frame: rst=1 at data bit 3 of 0x3C. Required: next edge tx_out=1, busy=0, data_ready=1 once rst=0; the next word 0x81 is sent cleanly with no residue.
- Minimum timing: CLKS_PER_BIT=1, DATA_WIDTH=5, send 0x15 (5 bits). Required: tx_out 0,1,0,1,0,1,1 on consecutive clocks; 7-clock frame.
- With UART_TX_BREAK_EN defined: send_break=1 for 20 clocks in IDLE. Required: tx_out=0 and busy=1 for those 20 clocks; data_valid is ignored until send_break=0; then tx_out=1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmit frame engine. Accepts one word per frame through a
//   valid/ready handshake and serialises it as start bit, DATA_WIDTH data
//   bits (LSB first), optional parity bit and one or two stop bits. Each
//   serial bit lasts CLKS_PER_BIT clocks. The serial line is registered and
//   idles high.
//
// Parameters
//   DATA_WIDTH   : data bits per frame (5..9)
//   CLKS_PER_BIT : clock cycles per serial bit (>= 1)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   data_in    in   frame payload, sent LSB first
//   data_valid in   source presents a word on data_in
//   data_ready out  engine accepts data_in this cycle (combinational)
//   par_en     in   1 = insert a parity bit after the data bits
//   par_type   in   0 = even parity, 1 = odd parity
//   stop2      in   0 = one stop bit, 1 = two stop bits
//   send_break in   (only with UART_TX_BREAK_EN) hold the line low from idle
//   busy       out  frame (or break) in progress
//   tx_out     out  registered serial line
//
// Optional feature
//   Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.

module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  busy,
  output logic                  tx_out
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                  state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    stop2_q, stop2_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;

  logic                    baud_last;
  logic                    stop_last;
  logic                    last_stop_clk;
  logic                    break_req;
  logic                    accept;
  logic [BW-1:0]           baud_next;
  logic [IW-1:0]           idx_inc;

`ifdef UART_TX_BREAK_EN
  assign break_req = send_break;
`else
  assign break_req = 1'b0;
`endif

  assign baud_last     = (baud_q == BAUD_LAST);
  assign baud_next     = baud_last ? '0 : baud_q + BW'(1);
  assign idx_inc       = idx_q + IW'(1);
  // In STOP the bit index counts stop bits; the second stop bit has index 1.
  assign stop_last     = !stop2_q || (idx_q == IDX_ONE);
  assign last_stop_clk = (state_q == STOP) && baud_last && stop_last;

  // A pending break outranks new data, so it also blocks acceptance in the
  // final stop clock and the engine drops to idle before entering BREAK.
  assign data_ready = !rst && !break_req && ((state_q == IDLE) || last_stop_clk);
  assign accept     = data_valid && data_ready;

  assign busy   = (state_q != IDLE);
  assign tx_out = tx_q;

  // State register and all datapath flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state logic. tx_d is the value the line takes for the bit that
  // starts on the next edge, so the line only moves at bit boundaries.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    parity_d = parity_q;
    tx_d     = tx_q;

    if (accept) begin
      data_d   = data_in;
      par_en_d = par_en;
      stop2_d  = stop2;
      parity_d = par_type ^ (^data_in);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        idx_d  = '0;
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
        end
`ifdef UART_TX_BREAK_EN
        else if (send_break) begin
          state_d = BREAK;
          tx_d    = 1'b0;
        end
`endif
      end

      START: begin
        baud_d = baud_next;
        if (baud_last) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end

      DATA: begin
        baud_d = baud_next;
        if (baud_last) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_inc;
            tx_d  = data_q[idx_inc];
          end
        end
      end

      PARITY: begin
        baud_d = baud_next;
        if (baud_last) begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        baud_d = baud_next;
        if (baud_last) begin
          if (!stop_last) begin
            idx_d = idx_inc;
            tx_d  = 1'b1;
          end else if (accept) begin
            state_d = START;
            idx_d   = '0;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            tx_d    = 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      BREAK: begin
        tx_d   = 1'b0;
        baud_d = '0;
        idx_d  = '0;
        if (!send_break) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Self-checking bench for uart_tx_frame. Two instances are used: one with
//   DATA_WIDTH=8, CLKS_PER_BIT=4 and one with DATA_WIDTH=5, CLKS_PER_BIT=1.
//   Expected per-clock line values are queued when a word is presented and
//   popped as the instance reports busy.

module tb_uart_tx_frame;

  logic clk = 1'b0;

  // Free-running 10-unit clock shared by both instances.
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       par_en;
  logic       par_type;
  logic       stop2;
  logic       busy;
  logic       tx_out;

  logic [4:0] m_data_in;
  logic       m_data_valid;
  logic       m_data_ready;
  logic       m_par_en;
  logic       m_par_type;
  logic       m_stop2;
  logic       m_busy;
  logic       m_tx_out;

`ifdef UART_TX_BREAK_EN
  logic       send_break;
  logic       m_send_break;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic tx;
    logic ready;
  } exp_t;

  exp_t main_q[$];
  exp_t min_q[$];
  bit   expect_break = 1'b0;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .busy       (busy),
    .tx_out     (tx_out)
  );

  uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut_min (
    .clk        (clk),
    .rst        (rst),
    .data_in    (m_data_in),
    .data_valid (m_data_valid),
    .data_ready (m_data_ready),
    .par_en     (m_par_en),
    .par_type   (m_par_type),
    .stop2      (m_stop2),
`ifdef UART_TX_BREAK_EN
    .send_break (m_send_break),
`endif
    .busy       (m_busy),
    .tx_out     (m_tx_out)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Build the per-clock line image of one frame and append it to a queue.
  // Only the very last clock of the frame has data_ready expected high.
  task automatic pushFrame(input bit to_min, input logic [8:0] word, input int dw,
                           input int clks, input bit pe, input bit pt, input bit s2);
    logic bits[$];
    logic par;
    exp_t e;
    par = pt;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(word[i]);
      par ^= word[i];
    end
    if (pe) bits.push_back(par);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < clks; c++) begin
        e.tx    = bits[b];
        e.ready = (b == bits.size() - 1) && (c == clks - 1);
        if (to_min) min_q.push_back(e);
        else        main_q.push_back(e);
      end
    end
  endtask

  // Compare the wide instance against its queue (or idle/break image).
  task automatic checkMain();
    exp_t e;
    if (expect_break) begin
      checkOutput("break_tx", tx_out, 1'b0);
      checkOutput("break_busy", busy, 1'b1);
      checkOutput("break_ready", data_ready, 1'b0);
    end else if (main_q.size() > 0) begin
      e = main_q.pop_front();
      checkOutput("tx_out", tx_out, e.tx);
      checkOutput("busy", busy, 1'b1);
      checkOutput("data_ready", data_ready, e.ready);
    end else begin
      checkOutput("idle_tx", tx_out, 1'b1);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_ready", data_ready, !rst);
    end
  endtask

  // Compare the minimal-timing instance against its queue.
  task automatic checkMin();
    exp_t e;
    if (min_q.size() > 0) begin
      e = min_q.pop_front();
      checkOutput("min_tx_out", m_tx_out, e.tx);
      checkOutput("min_busy", m_busy, 1'b1);
      checkOutput("min_ready", m_data_ready, e.ready);
    end else begin
      checkOutput("min_idle_tx", m_tx_out, 1'b1);
      checkOutput("min_idle_busy", m_busy, 1'b0);
      checkOutput("min_idle_ready", m_data_ready, !rst);
    end
  endtask

  // Advance one clock and sample both instances just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    checkMain();
    checkMin();
  endtask

  // Present one word to the wide instance for exactly the accepting clock.
  task automatic applyStimulus(input logic [7:0] word, input bit pe, input bit pt,
                               input bit s2);
    data_in    = word;
    par_en     = pe;
    par_type   = pt;
    stop2      = s2;
    data_valid = 1'b1;
    pushFrame(1'b0, {1'b0, word}, 8, 4, pe, pt, s2);
    tick();
    data_valid = 1'b0;
  endtask

  // Send one word and run the line until it is idle again.
  task automatic runFrame(input logic [7:0] word, input bit pe, input bit pt,
                          input bit s2);
    int len;
    len = 4 * (1 + 8 + int'(pe) + 1 + int'(s2));
    applyStimulus(word, pe, pt, s2);
    repeat (len - 1) tick();
    repeat (2) tick();
    checkOutput("main_queue_drained", main_q.size(), 0);
  endtask

  // Main sequence: reset, frames, parity, back-to-back, reset abort,
  // minimal timing, and the optional break.
  initial begin
    rst          = 1'b1;
    data_in      = '0;
    data_valid   = 1'b0;
    par_en       = 1'b0;
    par_type     = 1'b0;
    stop2        = 1'b0;
    m_data_in    = '0;
    m_data_valid = 1'b0;
    m_par_en     = 1'b0;
    m_par_type   = 1'b0;
    m_stop2      = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break   = 1'b0;
    m_send_break = 1'b0;
`endif

    $display("[TB] reset");
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("[TB] basic frame 0xA5");
    runFrame(8'hA5, 1'b0, 1'b0, 1'b0);

    $display("[TB] parity frames");
    runFrame(8'hA5, 1'b1, 1'b0, 1'b0);
    runFrame(8'hA5, 1'b1, 1'b1, 1'b0);
    runFrame(8'h01, 1'b1, 1'b0, 1'b0);

    $display("[TB] two stop bits, back-to-back");
    data_in    = 8'h00;
    par_en     = 1'b0;
    par_type   = 1'b0;
    stop2      = 1'b1;
    data_valid = 1'b1;
    pushFrame(1'b0, 9'h000, 8, 4, 1'b0, 1'b0, 1'b1);
    pushFrame(1'b0, 9'h0FF, 8, 4, 1'b0, 1'b0, 1'b1);
    tick();
    data_in = 8'hFF;
    repeat (44) tick();
    data_valid = 1'b0;
    repeat (43) tick();
    repeat (2) tick();
    checkOutput("b2b_queue_drained", main_q.size(), 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (16) tick();
    rst = 1'b1;
    main_q.delete();
    #1;
    checkOutput("ready_during_rst", data_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", data_ready, 1'b1);
    runFrame(8'h81, 1'b0, 1'b0, 1'b0);

    $display("[TB] minimum timing frame");
    m_data_in    = 5'h15;
    m_data_valid = 1'b1;
    pushFrame(1'b1, 9'h015, 5, 1, 1'b0, 1'b0, 1'b0);
    tick();
    m_data_valid = 1'b0;
    repeat (6) tick();
    repeat (2) tick();
    checkOutput("min_queue_drained", min_q.size(), 0);

`ifdef UART_TX_BREAK_EN
    $display("[TB] break");
    send_break = 1'b1;
    data_in    = 8'h55;
    data_valid = 1'b1;
    #1;
    checkOutput("ready_break_req", data_ready, 1'b0);
    expect_break = 1'b1;
    repeat (20) tick();
    send_break   = 1'b0;
    data_valid   = 1'b0;
    expect_break = 1'b0;
    repeat (2) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
